// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I instruction-decode stage.
// Holds the register file (with write-through bypass), the opcode decoder and
// immediate generator, load-use hazard detection and the ID/EX register.
// Optional build macro: ID_ILLEGAL_EN adds the id_illegal output. With it,
// unknown or malformed instructions travel down the pipe flagged instead of
// being squashed.
module id_stage_pipe #(
  parameter int              XLEN   = 32,
  parameter int              NREG   = 32,
  parameter logic [XLEN-1:0] RST_PC = '0,
  localparam int             RAW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            wb_reg_write,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_rd_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic [RAW-1:0]  id_rd,
  output logic [RAW-1:0]  id_rs1,
  output logic [RAW-1:0]  id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [2:0]      id_alu_op,
  output logic            id_alu_src,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_reg_write,
  output logic            id_jalr,
`ifdef ID_ILLEGAL_EN
  output logic            id_illegal,
`endif
  output logic [1:0]      id_branch
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Control bundle carried in the ID/EX register; a bubble is simply '0.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       jalr;
    logic [1:0] branch;
  } ctl_t;

  // Instruction fields; register addresses keep only RAW bits.
  logic [6:0]     w_opc;
  logic [RAW-1:0] w_rd, w_rs1, w_rs2;
  logic [2:0]     w_f3;
  logic [6:0]     w_f7;

  assign w_opc = if_instr[6:0];
  assign w_rd  = if_instr[7 +: RAW];
  assign w_rs1 = if_instr[15 +: RAW];
  assign w_rs2 = if_instr[20 +: RAW];
  assign w_f3  = if_instr[14:12];
  assign w_f7  = if_instr[31:25];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;

  // Writeback port; x0 is never written so it stays 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_reg_write && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_rd_data;
    end
  end

  // Asynchronous reads with same-cycle writeback bypass; x0 hardwired to 0.
  always_comb begin
    w_rs1_data = r_regs[w_rs1];
    w_rs2_data = r_regs[w_rs2];
    if (wb_reg_write && (wb_rd == w_rs1)) w_rs1_data = wb_rd_data;
    if (wb_reg_write && (wb_rd == w_rs2)) w_rs2_data = wb_rd_data;
    if (w_rs1 == '0) w_rs1_data = '0;
    if (w_rs2 == '0) w_rs2_data = '0;
  end

  // ---------------------------------------------------------------------------
  // Decode and immediate generation
  // ---------------------------------------------------------------------------
  ctl_t        w_ctl;
  logic [31:0] w_imm32;
  logic        w_known;
  logic        w_use_rs1, w_use_rs2;

  // Opcode -> control, immediate format and source-register usage.
  always_comb begin
    w_ctl     = '0;
    w_imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
    w_known   = 1'b1;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_ctl.alu_op    = 3'd0;
        w_ctl.reg_write = 1'b1;
        w_use_rs2       = 1'b1;
      end
      OPC_OPIMM: begin
        w_ctl.alu_op    = 3'd1;
        w_ctl.alu_src   = 1'b1;
        w_ctl.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        w_ctl.alu_op    = 3'd2;
        w_ctl.alu_src   = 1'b1;
        w_ctl.mem_read  = 1'b1;
        w_ctl.reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_ctl.alu_op    = 3'd2;
        w_ctl.alu_src   = 1'b1;
        w_ctl.mem_write = 1'b1;
        w_imm32         = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        w_use_rs2       = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctl.alu_op = 3'd3;
        w_ctl.branch = 2'd1;
        w_imm32      = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                        if_instr[30:25], if_instr[11:8], 1'b0};
        w_use_rs2    = 1'b1;
      end
      OPC_LUI: begin
        w_ctl.alu_op    = 3'd4;
        w_ctl.alu_src   = 1'b1;
        w_ctl.reg_write = 1'b1;
        w_imm32         = {if_instr[31:12], 12'b0};
        w_use_rs1       = 1'b0;
      end
      OPC_AUIPC: begin
        w_ctl.alu_op    = 3'd5;
        w_ctl.alu_src   = 1'b1;
        w_ctl.reg_write = 1'b1;
        w_imm32         = {if_instr[31:12], 12'b0};
        w_use_rs1       = 1'b0;
      end
      OPC_JAL: begin
        w_ctl.alu_op    = 3'd6;
        w_ctl.alu_src   = 1'b1;
        w_ctl.reg_write = 1'b1;
        w_ctl.branch    = 2'd2;
        w_imm32         = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                           if_instr[20], if_instr[30:21], 1'b0};
        w_use_rs1       = 1'b0;
      end
      OPC_JALR: begin
        w_ctl.alu_op    = 3'd6;
        w_ctl.alu_src   = 1'b1;
        w_ctl.reg_write = 1'b1;
        w_ctl.jalr      = 1'b1;
        w_ctl.branch    = 2'd3;
      end
      default: w_known = 1'b0;
    endcase
  end

  logic [XLEN-1:0] w_imm;
  assign w_imm = XLEN'($signed(w_imm32));

  // What the ID/EX register takes when an instruction is accepted.
  ctl_t w_ctl_ld;
  logic w_vld_ld;
`ifdef ID_ILLEGAL_EN
  logic w_illegal;
  assign w_illegal = !w_known || (if_instr[1:0] != 2'b11) ||
                     ((w_opc == OPC_OP) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
  assign w_ctl_ld  = w_illegal ? '0 : w_ctl;
  assign w_vld_ld  = 1'b1;
`else
  assign w_ctl_ld  = w_ctl;
  assign w_vld_ld  = w_known;
`endif

  // ---------------------------------------------------------------------------
  // Hazard and handshake
  // ---------------------------------------------------------------------------
  logic r_valid;
  ctl_t r_ctl;
  logic [RAW-1:0] r_rd, r_rs1, r_rs2;
  logic w_hz;

  assign w_hz = r_valid && r_ctl.mem_read && (r_rd != '0) && if_valid &&
                ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_rs2 && (w_rs2 == r_rd)));

  assign id_ready = flush || (ex_ready && !w_hz);

  // ---------------------------------------------------------------------------
  // ID/EX register: flush > EX stall > load-use bubble > load > idle bubble
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [2:0]      r_f3;
  logic [6:0]      r_f7;
`ifdef ID_ILLEGAL_EN
  logic            r_illegal;
`endif

  // Pipeline register update; data fields only change on a real load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_ctl      <= '0;
      r_pc       <= RST_PC;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_f3       <= '0;
      r_f7       <= '0;
`ifdef ID_ILLEGAL_EN
      r_illegal  <= 1'b0;
`endif
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_ctl     <= '0;
`ifdef ID_ILLEGAL_EN
      r_illegal <= 1'b0;
`endif
    end else if (ex_ready) begin
      if (w_hz || !if_valid) begin
        r_valid   <= 1'b0;
        r_ctl     <= '0;
`ifdef ID_ILLEGAL_EN
        r_illegal <= 1'b0;
`endif
      end else begin
        r_valid    <= w_vld_ld;
        r_ctl      <= w_ctl_ld;
        r_pc       <= if_pc;
        r_rs1_data <= w_rs1_data;
        r_rs2_data <= w_rs2_data;
        r_imm      <= w_imm;
        r_rd       <= w_rd;
        r_rs1      <= w_rs1;
        r_rs2      <= w_rs2;
        r_f3       <= w_f3;
        r_f7       <= w_f7;
`ifdef ID_ILLEGAL_EN
        r_illegal  <= w_illegal;
`endif
      end
    end
  end

  assign id_valid     = r_valid;
  assign id_pc        = r_pc;
  assign id_rs1_data  = r_rs1_data;
  assign id_rs2_data  = r_rs2_data;
  assign id_imm       = r_imm;
  assign id_rd        = r_rd;
  assign id_rs1       = r_rs1;
  assign id_rs2       = r_rs2;
  assign id_funct3    = r_f3;
  assign id_funct7    = r_f7;
  assign id_alu_op    = r_ctl.alu_op;
  assign id_alu_src   = r_ctl.alu_src;
  assign id_mem_read  = r_ctl.mem_read;
  assign id_mem_write = r_ctl.mem_write;
  assign id_reg_write = r_ctl.reg_write;
  assign id_jalr      = r_ctl.jalr;
  assign id_branch    = r_ctl.branch;
`ifdef ID_ILLEGAL_EN
  assign id_illegal   = r_illegal;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed decode vectors plus hand-written sequences for
// reset, bypass, load-use, EX stall and flush priority.
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam logic [31:0] RSTPC = 32'h0000_0100;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            ex_ready;
  logic            flush;
  logic            wb_reg_write;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_rd_data;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RAW-1:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [2:0]      id_alu_op;
  logic            id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_jalr;
  logic [1:0]      id_branch;

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .RST_PC(RSTPC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_jalr(id_jalr),
    .id_branch(id_branch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs sampled there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {alu_op, alu_src, mem_read, mem_write, reg_write, jalr, branch}
  function automatic logic [9:0] mkctl(input logic [2:0] op, input logic src,
      input logic mr, input logic mw, input logic rw, input logic jr, input logic [1:0] br);
    return {op, src, mr, mw, rw, jr, br};
  endfunction

  function automatic logic [9:0] dut_ctl();
    return {id_alu_op, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_jalr, id_branch};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        vld;
    logic        chk_imm;
    logic [31:0] imm;
    logic [9:0]  ctl;
    logic [9:0]  mask;
    logic [4:0]  rd;
  } vec_t;

  localparam logic [9:0] ALL   = 10'h3FF;
  localparam logic [9:0] NOSRC = 10'h3BF;   // alu_src left unchecked for jumps

  vec_t vt [11];

  // Instruction encodings used by the sequences
  localparam logic [31:0] ADD_X4_X3_X3 = 32'h0031_8233;
  localparam logic [31:0] ADD_X4_X5_X5 = 32'h0052_8233;
  localparam logic [31:0] ADD_X4_X0_X0 = 32'h0000_0233;
  localparam logic [31:0] LW_X6_0_X1   = 32'h0000_A303;
  localparam logic [31:0] ADDI_X7_X6_1 = 32'h0013_0393;
  localparam logic [31:0] LUI_X6_30    = 32'h0003_0337;
  localparam logic [31:0] ADDI_X1_M1   = 32'hFFF0_0093;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{"add",   ADD_X4_X3_X3,  32'h10, 1, 0, 32'h0,        mkctl(0,0,0,0,1,0,0), ALL,   5'd4};
    vt[1]  = '{"sub",   32'h4020_8233, 32'h14, 1, 0, 32'h0,        mkctl(0,0,0,0,1,0,0), ALL,   5'd4};
    vt[2]  = '{"addi",  ADDI_X1_M1,    32'h18, 1, 1, 32'hFFFFFFFF, mkctl(1,1,0,0,1,0,0), ALL,   5'd1};
    vt[3]  = '{"lw",    LW_X6_0_X1,    32'h1C, 1, 1, 32'h0,        mkctl(2,1,1,0,1,0,0), ALL,   5'd6};
    vt[4]  = '{"sw",    32'h0051_2423, 32'h20, 1, 1, 32'h8,        mkctl(2,1,0,1,0,0,0), ALL,   5'd8};
    vt[5]  = '{"beq",   32'hFE20_8EE3, 32'h24, 1, 1, 32'hFFFFFFFC, mkctl(3,0,0,0,0,0,1), ALL,   5'd29};
    vt[6]  = '{"jal",   32'h0010_00EF, 32'h28, 1, 1, 32'h800,      mkctl(6,0,0,0,1,0,2), NOSRC, 5'd1};
    vt[7]  = '{"jalr",  32'h0040_8067, 32'h2C, 1, 1, 32'h4,        mkctl(6,0,0,0,1,1,3), NOSRC, 5'd0};
    vt[8]  = '{"lui",   LUI_X6_30,     32'h30, 1, 1, 32'h0003_0000, mkctl(4,1,0,0,1,0,0), ALL,  5'd6};
    vt[9]  = '{"auipc", 32'hFFFF_F117, 32'h34, 1, 1, 32'hFFFFF000, mkctl(5,1,0,0,1,0,0), ALL,   5'd2};
    vt[10] = '{"unk",   32'h0000_007F, 32'h38, 0, 0, 32'h0,        10'h0,                ALL,   5'd0};

    rst = 1'b0; if_valid = 0; if_instr = '0; if_pc = '0; ex_ready = 0; flush = 0;
    wb_reg_write = 0; wb_rd = '0; wb_rd_data = '0;
    tick; tick;
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, RSTPC);
    chk("rst_ctl", {22'b0, dut_ctl()}, 32'd0);
    rst = 1'b1;
    ex_ready = 1'b1;
    #1;
    chk("rst_ready", {31'b0, id_ready}, 32'd1);

    // Decode table: one instruction per cycle, checked one cycle later.
    for (int i = 0; i < 11; i++) begin
      if_valid = 1'b1; if_instr = vt[i].instr; if_pc = vt[i].pc;
      tick;
      if_valid = 1'b0;
      chk({vt[i].name, "_valid"}, {31'b0, id_valid}, {31'b0, vt[i].vld});
      chk({vt[i].name, "_ctl"}, {22'b0, dut_ctl() & vt[i].mask}, {22'b0, vt[i].ctl & vt[i].mask});
      if (vt[i].vld) begin
        chk({vt[i].name, "_pc"}, id_pc, vt[i].pc);
        chk({vt[i].name, "_rd"}, {27'b0, id_rd}, {27'b0, vt[i].rd});
      end
      if (vt[i].chk_imm) chk({vt[i].name, "_imm"}, id_imm, vt[i].imm);
    end
    tick;

    // Reset mid-stream clears ID/EX and the register file.
    wb_reg_write = 1; wb_rd = 5'd5; wb_rd_data = 32'h55;
    tick;
    wb_reg_write = 0;
    if_valid = 1; if_instr = ADD_X4_X5_X5; if_pc = 32'h40;
    tick;
    chk("pre_rst_valid", {31'b0, id_valid}, 32'd1);
    chk("pre_rst_x5", id_rs1_data, 32'h55);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
    chk("mid_rst_pc", id_pc, RSTPC);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk("post_rst_valid", {31'b0, id_valid}, 32'd1);
    chk("post_rst_x5", id_rs1_data, 32'h0);
    if_valid = 0;

    // Bypass: writeback and read of x3 in the same cycle.
    wb_reg_write = 1; wb_rd = 5'd3; wb_rd_data = 32'hDEADBEEF;
    if_valid = 1; if_instr = ADD_X4_X3_X3; if_pc = 32'h50;
    tick;
    chk("byp_rs1", id_rs1_data, 32'hDEADBEEF);
    chk("byp_rs2", id_rs2_data, 32'hDEADBEEF);
    wb_rd = 5'd0; wb_rd_data = 32'h1234_5678;
    if_instr = ADD_X4_X0_X0;
    tick;
    chk("x0_byp", id_rs1_data, 32'h0);
    wb_reg_write = 0;
    tick;
    chk("x0_after", id_rs2_data, 32'h0);
    if_instr = ADD_X4_X3_X3;
    tick;
    chk("x3_kept", id_rs1_data, 32'hDEADBEEF);

    // Load-use: lw x6 then addi x7,x6,1 -> one bubble.
    if_instr = LW_X6_0_X1; if_pc = 32'h60;
    tick;
    if_instr = ADDI_X7_X6_1; if_pc = 32'h64;
    #1;
    chk("lu_ready", {31'b0, id_ready}, 32'd0);
    tick;
    chk("lu_bubble", {31'b0, id_valid}, 32'd0);
    chk("lu_ready2", {31'b0, id_ready}, 32'd1);
    tick;
    chk("lu_issue_v", {31'b0, id_valid}, 32'd1);
    chk("lu_issue_rd", {27'b0, id_rd}, 32'd7);
    chk("lu_issue_pc", id_pc, 32'h64);
    // LUI consumer does not read rs1: no stall.
    if_instr = LW_X6_0_X1; if_pc = 32'h68;
    tick;
    if_instr = LUI_X6_30; if_pc = 32'h6C;
    #1;
    chk("lui_ready", {31'b0, id_ready}, 32'd1);
    tick;
    chk("lui_valid", {31'b0, id_valid}, 32'd1);
    chk("lui_op", {29'b0, id_alu_op}, 32'd4);

    // Downstream stall for 3 cycles holds ID/EX.
    if_instr = ADD_X4_X3_X3; if_pc = 32'h70;
    tick;
    if_instr = ADDI_X1_M1; if_pc = 32'h74;
    ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", {31'b0, id_ready}, 32'd0);
      tick;
      chk("stall_hold_pc", id_pc, 32'h70);
      chk("stall_hold_v", {31'b0, id_valid}, 32'd1);
    end
    ex_ready = 1;
    #1;
    chk("unstall_ready", {31'b0, id_ready}, 32'd1);
    tick;
    chk("unstall_rd", {27'b0, id_rd}, 32'd1);
    chk("unstall_imm", id_imm, 32'hFFFFFFFF);

    // Flush beats EX stall and load-use hazard.
    if_instr = LW_X6_0_X1; if_pc = 32'h80;
    tick;
    if_instr = ADDI_X7_X6_1; if_pc = 32'h84;
    ex_ready = 0; flush = 1;
    #1;
    chk("fl_ready", {31'b0, id_ready}, 32'd1);
    tick;
    chk("fl_valid", {31'b0, id_valid}, 32'd0);
    chk("fl_memrd", {31'b0, id_mem_read}, 32'd0);
    flush = 0; if_valid = 0; ex_ready = 1;
    tick;
    chk("fl_dropped", {31'b0, id_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
